// File: rtl/result_addr_pkg.sv
// Shared defaults, control-state encoding and width helper for the
// multi-channel result address generator.
package result_addr_pkg;

  localparam logic [31:0] SLOT_BYTES_DEF = 32'h0000_060E;
  localparam logic [31:0] BASE_ADDR_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALLOC   = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  // Channel index width; a single channel still needs a one-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_prio_arbiter.sv
// Fixed-priority arbiter: the lowest-index request wins. Produces a
// one-hot grant, the binary index of the winner and an any-request flag.
module fixed_prio_arbiter
  import result_addr_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]       req,
  output logic [NUM_CH-1:0]       gnt,
  output logic [ch_w(NUM_CH)-1:0] idx,
  output logic                    any
);

  localparam int CH_W = ch_w(NUM_CH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = CH_W'(i);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/result_address_gen.sv
// Multi-channel result-buffer slot allocator over a circular SRAM region,
// with occupancy tracking, drop counting and underflow detection.
module result_address_gen
  import result_addr_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] SLOT_BYTES = ADDR_W'(SLOT_BYTES_DEF),
  parameter int                NUM_SLOTS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BASE_ADDR_DEF),
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              inc_addr,
  output logic [NUM_CH-1:0]              grant,
  output logic [ADDR_W-1:0]              addr_out,
  output logic [ch_w(NUM_CH)-1:0]        ch_out,
  output logic                           write_enable,
  input  logic                           slot_free,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy,
  output logic                           full,
  output logic                           empty,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic                           underflow,
  input  logic                           clr_err
);

  localparam int                CH_W     = ch_w(NUM_CH);
  localparam int                OCC_W    = $clog2(NUM_SLOTS + 1);
  localparam int                IDX_W    = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(NUM_SLOTS);

  logic [NUM_CH-1:0] gnt_s;
  logic [CH_W-1:0]   win_s;
  logic              req_any_s;
  logic              alloc_s;
  logic              drop_s;
  logic [OCC_W-1:0]  occ_nxt_s;
  logic              und_set_s;
  state_e            state_nxt_s;

  state_e            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CH_W-1:0]   ch_r;
  logic [NUM_CH-1:0] grant_r;
  logic [OCC_W-1:0]  occ_r;
  logic              full_r;
  logic              empty_r;
  logic [CNT_W-1:0]  drop_r;
  logic              und_r;

  fixed_prio_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (inc_addr),
    .gnt (gnt_s),
    .idx (win_s),
    .any (req_any_s)
  );

  // Allocation and drop are judged on the registered (pre-free) full flag.
  assign alloc_s = req_any_s & ~full_r;
  assign drop_s  = req_any_s &  full_r;

  // Occupancy next value; allocation with a same-cycle free cancels out.
  always_comb begin
    occ_nxt_s = occ_r;
    und_set_s = 1'b0;
    case ({alloc_s, slot_free})
      2'b10: occ_nxt_s = occ_r + OCC_W'(1);
      2'b01: begin
        if (empty_r) begin
          und_set_s = 1'b1;
        end else begin
          occ_nxt_s = occ_r - OCC_W'(1);
        end
      end
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Control state: ALLOC while a slot is being handed out, BLOCKED when refused.
  always_comb begin
    if (alloc_s) begin
      state_nxt_s = ALLOC;
    end else if (drop_s) begin
      state_nxt_s = BLOCKED;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Slot pointer, address, grant and status registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      addr_r  <= BASE_ADDR;
      ch_r    <= '0;
      grant_r <= '0;
      occ_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      occ_r   <= occ_nxt_s;
      full_r  <= (occ_nxt_s == FULL_OCC);
      empty_r <= (occ_nxt_s == '0);
      if (alloc_s) begin
        ch_r    <= win_s;
        grant_r <= gnt_s;
        if (idx_r == LAST_IDX) begin
          idx_r  <= '0;
          addr_r <= BASE_ADDR;
        end else begin
          idx_r  <= idx_r + IDX_W'(1);
          addr_r <= addr_r + SLOT_BYTES;
        end
      end else begin
        grant_r <= '0;
      end
    end
  end

  // Error bookkeeping; a clear wins over a same-cycle increment or set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_r <= '0;
      und_r  <= 1'b0;
    end else if (clr_err) begin
      drop_r <= '0;
      und_r  <= 1'b0;
    end else begin
      if (drop_s && (drop_r != {CNT_W{1'b1}})) begin
        drop_r <= drop_r + CNT_W'(1);
      end else begin
        drop_r <= drop_r;
      end
      und_r <= und_r | und_set_s;
    end
  end

  assign write_enable = (state_r == ALLOC);
  assign grant        = grant_r;
  assign addr_out     = addr_r;
  assign ch_out       = ch_r;
  assign occupancy    = occ_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign drop_cnt     = drop_r;
  assign underflow    = und_r;

endmodule

// File: tb/tb_result_address_gen.sv
// Scoreboard bench for result_address_gen: an abstract model predicts each
// handed-out slot and the status flags; a negedge monitor checks the DUT.
module tb_result_address_gen;

  localparam int          ADDR_W    = 32;
  localparam int          NUM_SLOTS = 8;
  localparam int          NUM_CH    = 4;
  localparam int          CNT_W     = 16;
  localparam logic [31:0] SLOT      = 32'h0000_060E;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NUM_CH-1:0] inc_addr = '0;
  logic [NUM_CH-1:0] grant;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        ch_out;
  logic              write_enable;
  logic              slot_free = 1'b0;
  logic [3:0]        occupancy;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  drop_cnt;
  logic              underflow;
  logic              clr_err = 1'b0;

  result_address_gen #(
    .ADDR_W(ADDR_W), .SLOT_BYTES(SLOT), .NUM_SLOTS(NUM_SLOTS),
    .BASE_ADDR(BASE), .NUM_CH(NUM_CH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .inc_addr(inc_addr), .grant(grant),
    .addr_out(addr_out), .ch_out(ch_out), .write_enable(write_enable),
    .slot_free(slot_free), .occupancy(occupancy), .full(full),
    .empty(empty), .drop_cnt(drop_cnt), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ch;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  // Model state: number of allocations since reset, slots held, error counters.
  int   m_allocs;
  int   m_occ;
  int   m_drop;
  bit   m_und;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_allocs = 0;
    m_occ    = 0;
    m_drop   = 0;
    m_und    = 1'b0;
    q.delete();
  endtask

  // Abstract rules: slot k (1-based count) lives at BASE + (k mod NUM_SLOTS)*SLOT.
  task automatic model_cycle(input logic [NUM_CH-1:0] req, input bit fr, input bit clr);
    int   win;
    exp_t e;
    win = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (req[i] && win < 0) win = i;
    if (win >= 0 && m_occ < NUM_SLOTS) begin
      m_allocs++;
      e.addr = BASE + 32'((m_allocs % NUM_SLOTS) * SLOT);
      e.ch   = win;
      q.push_back(e);
      if (!fr) m_occ++;
    end else begin
      if (win >= 0 && m_drop < 65535) m_drop++;
      if (fr) begin
        if (m_occ > 0) m_occ--;
        else m_und = 1'b1;
      end
    end
    if (clr) begin
      m_drop = 0;
      m_und  = 1'b0;
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] req, input bit fr, input bit clr);
    inc_addr  = req;
    slot_free = fr;
    clr_err   = clr;
    @(posedge clk);
    model_cycle(req, fr, clr);
    #1;
    inc_addr  = '0;
    slot_free = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_addr", 64'(addr_out), 64'(BASE));
    chk("rst_ch", 64'(ch_out), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_und", 64'(underflow), 64'd0);
  endtask

  // Called 1 time unit after a posedge: assert reset asynchronously, check, release.
  task automatic do_reset();
    chk_en = 1'b0;
    n_rst  = 1'b0;
    inc_addr  = '0;
    slot_free = 1'b0;
    clr_err   = 1'b0;
    model_reset();
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    check_reset_values();
    n_rst  = 1'b1;
    chk_en = 1'b1;
  endtask

  // Monitor: pop an expectation on every write_enable, and track status flags.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      if (write_enable) begin
        if (q.size() == 0) begin
          chk("spurious_we", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("addr", 64'(addr_out), 64'(e.addr));
          chk("ch", 64'(ch_out), 64'(e.ch));
          chk("grant", 64'(grant), 64'(4'b0001 << e.ch));
        end
      end else begin
        chk("missing_we", 64'(q.size()), 64'd0);
        chk("idle_grant", 64'(grant), 64'd0);
      end
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("full", 64'(full), 64'(m_occ == NUM_SLOTS));
      chk("empty", 64'(empty), 64'(m_occ == 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("underflow", 64'(underflow), 64'(m_und));
    end
  end

  initial begin
    logic [NUM_CH-1:0] r;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Four spaced single-cycle requests on channel 0.
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      chk("spaced_we", 64'(write_enable), 64'd1);
      chk("spaced_addr", 64'(addr_out), 64'(SLOT * 32'(k + 1)));
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
    end

    // Two requesters held two cycles: channel 1 wins both.
    do_reset();
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    chk("prio_ch", 64'(ch_out), 64'd1);
    step(4'b0000, 1'b0, 1'b0);
    chk("prio_occ", 64'(occupancy), 64'd2);

    // Fill, overflow by three request-cycles, free one, allocate across the wrap.
    do_reset();
    for (int k = 0; k < NUM_SLOTS; k++) step(4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0101, 1'b0, 1'b0);
    chk("full_drop", 64'(drop_cnt), 64'd3);
    chk("full_hold_addr", 64'(addr_out), 64'(BASE));
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // Request and free every cycle: occupancy stays at one, addresses wrap.
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b0001, 1'b1, 1'b0);
    chk("interleave_occ", 64'(occupancy), 64'd1);

    // Free while empty, then clear errors.
    do_reset();
    step(4'b0000, 1'b1, 1'b0);
    chk("und_set", 64'(underflow), 64'd1);
    step(4'b0000, 1'b1, 1'b1);
    chk("und_clr", 64'(underflow), 64'd0);

    // Randomised traffic.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      step(r, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset in the middle of a burst, during a write_enable cycle.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("pre_rst_we", 64'(write_enable), 64'd1);
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    chk("post_rst_addr", 64'(addr_out), 64'(SLOT));
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
